// File: rtl/alu_mc_pkg.sv
// Shared op codes and FSM states for the handshaked multi-cycle ALU.
package alu_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_SHL1 = 3'b010,
        OP_CMP  = 3'b011,
        OP_SHLV = 3'b100,
        OP_SHRV = 3'b101,
        OP_AND  = 3'b110,
        OP_MUL  = 3'b111
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_mc_if.sv
// Operand/result valid-ready bundle between the control unit and alu_mc.
interface alu_mc_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    op_e              op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Y;
    logic             carry;
    logic             zero;
    logic             busy;

    modport master (
        output in_valid, A, B, op, out_ready,
        input  in_ready, out_valid, Y, carry, zero, busy
    );

    modport slave (
        input  in_valid, A, B, op, out_ready,
        output in_ready, out_valid, Y, carry, zero, busy
    );
endinterface

// File: rtl/alu_mc_mul_seq.sv
// Shift-add multiplier: one partial product per clock, WIDTH iterations after start.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CNT_W = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand, acc, acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;
    logic               running;

    // product is the accumulator value being written on the final iteration edge
    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign done     = running && (cnt == CNT_W'(WIDTH-1));
    assign product  = acc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            mcand   <= {{WIDTH{1'b0}}, a};
            mplier  <= b;
            acc     <= '0;
            cnt     <= '0;
            running <= 1'b1;
        end else if (running) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done) running <= 1'b0;
        end
    end
endmodule

// File: rtl/alu_mc.sv
// Handshaked ALU: single-cycle ops registered on accept, MUL via iterative sequencer.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input logic     clk,
    input logic     rst,
    alu_mc_if.slave bus
);
    state_e             state;
    logic [WIDTH-1:0]   y_r, res_y;
    logic               carry_r, zero_r, out_valid_r, busy_r, res_c;
    logic               accept, mul_start, mul_done;
    logic [2*WIDTH-1:0] mul_prod, ext_l, ext_r;
    logic [SHAMT_W-1:0] s;

    assign bus.in_ready  = (state == S_IDLE) && (!out_valid_r || bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign mul_start     = accept && (bus.op == OP_MUL);
    assign bus.Y         = y_r;
    assign bus.carry     = carry_r;
    assign bus.zero      = zero_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;

    // Widened shifts: the bit adjacent to the result field is the last one shifted out
    assign s     = bus.B[SHAMT_W-1:0];
    assign ext_l = {{WIDTH{1'b0}}, bus.A} << s;
    assign ext_r = {bus.A, {WIDTH{1'b0}}} >> s;

    always_comb begin
        res_y = '0;
        res_c = 1'b0;
        case (bus.op)
            OP_ADD:  {res_c, res_y} = {1'b0, bus.A} + {1'b0, bus.B};
            OP_SUB:  {res_c, res_y} = {1'b0, bus.A} - {1'b0, bus.B};
            OP_SHL1: {res_c, res_y} = {bus.A, 1'b0};
            OP_CMP: begin
                res_y = WIDTH'(bus.A == bus.B);
                res_c = bus.A < bus.B;
            end
            OP_SHLV: {res_c, res_y} = ext_l[WIDTH:0];
            OP_SHRV: {res_y, res_c} = ext_r[2*WIDTH-1:WIDTH-1];
            OP_AND:  res_y = bus.A & bus.B;
            default: ;
        endcase
    end

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (bus.A),
        .b       (bus.B),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            y_r         <= '0;
            carry_r     <= 1'b0;
            zero_r      <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            // A result written below on this same edge overrides the drain
            if (out_valid_r && bus.out_ready) out_valid_r <= 1'b0;
            case (state)
                S_IDLE: if (accept) begin
                    if (bus.op == OP_MUL) begin
                        state  <= S_MUL;
                        busy_r <= 1'b1;
                    end else begin
                        y_r         <= res_y;
                        carry_r     <= res_c;
                        zero_r      <= (res_y == '0);
                        out_valid_r <= 1'b1;
                    end
                end
                S_MUL: if (mul_done) begin
                    y_r         <= mul_prod[WIDTH-1:0];
                    carry_r     <= |mul_prod[2*WIDTH-1:WIDTH];
                    zero_r      <= (mul_prod[WIDTH-1:0] == '0);
                    out_valid_r <= 1'b1;
                    busy_r      <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Directed and randomized checks of alu_mc against an arithmetic reference model.
module tb_alu_mc;
    import alu_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_mc_if #(.WIDTH(W)) bus ();

    alu_mc #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [W-1:0] y;
        logic         c;
        logic         z;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference behaviour in plain integer arithmetic on the operand values
    function automatic exp_t model(input int op, input int a, input int b);
        exp_t e;
        int   r, c, s;
        s = b % W;
        r = 0;
        c = 0;
        case (op)
            0: begin r = a + b;       c = (r >= 256); end
            1: begin r = a - b + 256; c = (a < b);    end
            2: begin r = a * 2;       c = (a >= 128); end
            3: begin r = (a == b);    c = (a < b);    end
            4: begin r = a * (1 << s); c = (s == 0) ? 0 : ((a >> (W - s)) & 1); end
            5: begin r = a / (1 << s); c = (s == 0) ? 0 : ((a >> (s - 1)) & 1); end
            6: begin r = a & b;       c = 0;          end
            default: begin r = a * b; c = (r >= 256); end
        endcase
        e.y = W'(r % 256);
        e.c = (c != 0);
        e.z = ((r % 256) == 0);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int op, input int a, input int b);
        bus.in_valid = 1'b1;
        bus.op       = op_e'(3'(op));
        bus.A        = W'(a);
        bus.B        = W'(b);
    endtask

    task automatic chk_out(input string tag, input int op, input int a, input int b);
        exp_t e;
        e = model(op, a, b);
        chk({tag, "_y"}, 32'(bus.Y), 32'(e.y));
        chk({tag, "_c"}, 32'(bus.carry), 32'(e.c));
        chk({tag, "_z"}, 32'(bus.zero), 32'(e.z));
        chk({tag, "_v"}, 32'(bus.out_valid), 1);
    endtask

    initial begin
        logic acc, take;
        logic [W-1:0] gy;
        logic gc, gz;
        int op, a, b, n;
        exp_t e;

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.A = '0; bus.B = '0; bus.op = OP_ADD;
        tick(); tick();
        chk("rst_ov", 32'(bus.out_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_y", 32'(bus.Y), 0);
        chk("rst_flags", {30'd0, bus.carry, bus.zero}, 0);
        chk("rst_ir", 32'(bus.in_ready), 1);
        rst = 1'b0;

        // ADD with carry-out
        drive(0, 'hF0, 'h20); tick(); bus.in_valid = 1'b0;
        chk_out("add", 0, 'hF0, 'h20);
        chk("add_y_lit", 32'(bus.Y), 'h10);

        // Back-to-back single-cycle ops
        drive(1, 3, 5);       chk("b2b_ir0", 32'(bus.in_ready), 1); tick();
        chk_out("sub", 1, 3, 5);
        drive(3, 9, 9);       chk("b2b_ir1", 32'(bus.in_ready), 1); tick();
        chk_out("cmp", 3, 9, 9);
        drive(5, 'h81, 7);    chk("b2b_ir2", 32'(bus.in_ready), 1); tick();
        chk_out("shrv", 5, 'h81, 7);
        bus.in_valid = 1'b0; tick();

        // MUL latency, busy and stall window; in_valid noise during MUL is ignored
        drive(7, 'h10, 'h11); tick();
        drive(0, 1, 2);
        for (int k = 1; k <= W; k++) begin
            chk("mul_busy", 32'(bus.busy), 1);
            chk("mul_ir", 32'(bus.in_ready), 0);
            chk("mul_ov", 32'(bus.out_valid), 0);
            tick();
        end
        bus.in_valid = 1'b0;
        chk_out("mul", 7, 'h10, 'h11);
        chk("mul_busy_end", 32'(bus.busy), 0);
        tick();

        // Backpressure: result held, pending AND waits for out_ready
        bus.out_ready = 1'b0;
        drive(0, 1, 1); tick();
        drive(6, 'hFF, 'h00);
        for (int k = 0; k < 4; k++) begin
            chk_out("bp_hold", 0, 1, 1);
            chk("bp_ir", 32'(bus.in_ready), 0);
            tick();
        end
        bus.out_ready = 1'b1; #1;
        chk("bp_ir_release", 32'(bus.in_ready), 1);
        tick(); bus.in_valid = 1'b0;
        chk_out("bp_and", 6, 'hFF, 'h00);

        // Shift boundaries
        drive(4, 'h81, 'h08); tick();
        chk_out("shlv0", 4, 'h81, 'h08);
        drive(2, 'h81, 0); tick(); bus.in_valid = 1'b0;
        chk_out("shl1", 2, 'h81, 0);
        tick();

        // Reset aborts a multiply in flight
        drive(7, 5, 7); tick(); bus.in_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("abort_ov", 32'(bus.out_valid), 0);
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_ir", 32'(bus.in_ready), 1);
        chk("abort_y", 32'(bus.Y), 0);
        n = 0;
        for (int k = 0; k < 2 * W; k++) begin
            if (bus.out_valid) n++;
            tick();
        end
        chk("abort_no_result", n, 0);

        // Randomized traffic against the scoreboard
        for (int i = 0; i < 600; i++) begin
            op = int'($urandom_range(0, 7));
            a  = int'($urandom_range(0, 255));
            b  = int'($urandom_range(0, 255));
            drive(op, a, b);
            bus.in_valid  = ($urandom_range(0, 2) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            acc  = bus.in_valid && bus.in_ready;
            take = bus.out_valid && bus.out_ready;
            gy = bus.Y; gc = bus.carry; gz = bus.zero;
            if (bus.out_valid && q.size() == 0) chk("rnd_spurious_ov", 1, 0);
            tick();
            if (take && q.size() != 0) begin
                e = q.pop_front();
                chk("rnd_y", 32'(gy), 32'(e.y));
                chk("rnd_c", 32'(gc), 32'(e.c));
                chk("rnd_z", 32'(gz), 32'(e.z));
            end
            if (acc) q.push_back(model(op, a, b));
        end

        // Drain with a bounded wait
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4 * W && q.size() != 0; k++) begin
            #1;
            take = bus.out_valid;
            gy = bus.Y; gc = bus.carry; gz = bus.zero;
            tick();
            if (take) begin
                e = q.pop_front();
                chk("drain_y", 32'(gy), 32'(e.y));
                chk("drain_c", 32'(gc), 32'(e.c));
                chk("drain_z", 32'(gz), 32'(e.z));
            end
        end
        chk("drain_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Parametrised, handshaked multi-cycle successor to the 8-bit single-cycle ALU in the TISC datapath. Registers results with carry/zero flags and adds variable shifts, AND, and an iterative shift-add multiplier. Uses valid/ready on both sides so the control unit can stall on multiply or output backpressure. Op codes 000-011 reproduce the prior ALU results.

Parameters:
WIDTH, 8, operand/result width (>=2)
SHAMT_W, $clog2(WIDTH), shift-amount bits taken from B[SHAMT_W-1:0]

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  operands/op presented
in_ready  out  1  block accepts when in_valid && in_ready at posedge
A  in  WIDTH  operand A
B  in  WIDTH  operand B / shift amount
op  in  3  operation code (alu_pkg)
out_valid  out  1  Y/flags valid
out_ready  in  1  consumer takes result when out_valid && out_ready
Y  out  WIDTH  result
carry  out  1  carry/borrow/overflow flag
zero  out  1  Y == 0
busy  out  1  multiply in progress

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE, Y=0, carry=0, zero=0, out_valid=0, busy=0, multiplier regs cleared. rst has priority over all other events, including mid-multiply (abort, result discarded).
- in_ready = (state==IDLE) && (!out_valid || out_ready). Combinational; no dependence on in_valid.
- Output register: out_valid cleared on out_valid && out_ready unless a new result is written on the same edge (new result wins, out_valid stays 1). Y/carry/zero are held stable while out_valid && !out_ready.
- Ops (single-cycle; result registered on the accept edge; latency 1; throughput 1/cycle when out_ready=1):
  - 000 ADD: Y=A+B; carry=carry-out.
  - 001 SUB: Y=A-B; carry=borrow (A<B unsigned).
  - 010 SHL1: Y=A<<1; carry=A[WIDTH-1].
  - 011 CMP: Y=(A==B)?1:0 zero-extended; carry=(A<B unsigned).
  - 100 SHLV: Y=A<<s, s=B[SHAMT_W-1:0]; carry=last bit shifted out (0 if s=0).
  - 101 SHRV: logical Y=A>>s; carry=last bit shifted out (0 if s=0).
  - 110 AND: Y=A&B; carry=0.
  - 111 MUL: multi-cycle, below.
- zero = (Y_next == 0), computed on the value being written.
- MUL FSM: IDLE -> MUL on accept with op=111: load mcand (2*WIDTH, zero-extended A), mplier=B, acc=0, cnt=0, busy=1. In MUL, each edge: if mplier[0], acc+=mcand; mcand<<=1; mplier>>=1; cnt++. On the edge where cnt==WIDTH-1: write Y=product[WIDTH-1:0], carry=|product[2*WIDTH-1:WIDTH] (overflow), zero, out_valid=1; state->IDLE; busy=0.
- MUL latency: accept edge + WIDTH iteration edges, so out_valid rises WIDTH+1 cycles after the accept cycle. in_ready=0 throughout MUL.
- Accepting MUL requires an empty or draining output slot, so out_valid is guaranteed 0 when MUL completes. No stall state is needed.
- A, B, op are sampled only at accept. Changes while busy are ignored.
- Wrap-around: ADD/SUB/MUL results are truncated mod 2^WIDTH. Flags carry the lost information.

Decomposition:
- alu_pkg: op enum (OP_ADD=3'b000, OP_SUB, OP_SHL1, OP_CMP, OP_SHLV, OP_SHRV, OP_AND, OP_MUL=3'b111), OP_W=3, state enum {S_IDLE, S_MUL}.
- Sub-module alu_mul_seq: shift-add iteration datapath (start, done, product). alu_mc owns the handshake, output register, and single-cycle ops.

Test Plan:
- rst=1 mid-MUL (A=5,B=7, 3 cycles in) -> next cycle out_valid=0, busy=0, in_ready=1, Y=0. Product never appears.
- WIDTH=8, ADD A=0xF0,B=0x20 accepted at cycle t -> cycle t+1: Y=0x10, carry=1, zero=0, out_valid=1.
- Back-to-back, out_ready=1: SUB 3-5, then CMP 9==9, then SHRV 0x81 by 7 -> consecutive outputs Y=0xFE,carry=1; Y=0x01,carry=0; Y=0x01,carry=0. in_ready held 1.
- MUL A=0x10,B=0x11 at t -> out_valid at t+9, Y=0x10, carry=1. busy=1 and in_ready=0 for t+1..t+8.
- Backpressure: ADD 1+1 with out_ready=0 for 4 cycles -> Y=0x02 held, in_ready=0, a new in_valid is not accepted. Raising out_ready with a pending AND 0xFF&0x00 -> the AND is accepted the same cycle, next Y=0x00, zero=1.
- SHLV A=0x81,B=0x08 (s=0) -> Y=0x81, carry=0. SHL1 A=0x81 -> Y=0x02, carry=1.
